// File: rtl/approx_div_12_6_seq.sv
// Sequential restoring divider: DW-bit dividend by VW-bit divisor,
// one quotient bit per clock under a start/done handshake.
module approx_div_12_6_seq #(
    parameter int DW = 12,
    parameter int VW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dz,
    output logic          ovf
);

    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [DW-1:0] q;
    logic [VW-1:0] d;
    logic [VW-1:0] r;
    logic [CW-1:0] cnt;

    logic [VW:0]   r_sh;
    logic [VW-1:0] r_diff;
    logic [VW-1:0] r_new;
    logic          ge;
    logic [DW-1:0] q_new;
    logic          last;
    logic          d_zero;

    // Remainder stays below D, so only the shifted value needs the extra bit;
    // when ge holds, the true difference fits in VW bits.
    always_comb begin
        r_sh   = {r, q[DW-1]};
        ge     = (r_sh >= {1'b0, d});
        r_diff = r_sh[VW-1:0] - d;
        r_new  = ge ? r_diff : r_sh[VW-1:0];
        q_new  = {q[DW-2:0], ge};
        last   = (cnt == CW'(DW - 1));
        d_zero = (d == '0);
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = DIV;
            end
            DIV: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            q         <= '0;
            d         <= '0;
            r         <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dz        <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        q   <= dividend;
                        d   <= divisor;
                        r   <= '0;
                        cnt <= '0;
                    end
                end
                DIV: begin
                    q   <= q_new;
                    r   <= r_new;
                    cnt <= cnt + 1'b1;
                    // Publish results on the edge that enters DONE
                    if (last) begin
                        quotient  <= d_zero ? '1 : q_new;
                        remainder <= d_zero ? '0 : r_new;
                        dz        <= d_zero;
                        ovf       <= d_zero | (|q_new[DW-1:VW]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
